// File: rtl/rtype_exec_wb.sv
// Execute/writeback stage for decoded R-type instructions: owns the 32x32
// register file and ALU, and steps each accepted instruction IDLE -> EXEC -> WB.
module rtype_exec_wb #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    alu_op,
    input  logic          write_reg,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    input  logic [4:0]    rd_addr,
    input  logic          ld_en,
    input  logic [4:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_result,
    output logic          zero_flag,
    output logic          ovf_flag,
    output logic          done,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    // Handshake: an instruction transfers on a rising edge where instr_valid
    // and instr_ready are both high and ld_en is low; instr_ready is high only in IDLE.
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] regs [NREG];

    logic [3:0]    op_q;
    logic          wr_q;
    logic [4:0]    rs_q;
    logic [4:0]    rt_q;
    logic [4:0]    rd_q;

    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic [DW-1:0] res;
    logic          ovf;
    logic          accept;

    assign a        = (rs_q == 5'd0) ? '0 : regs[rs_q];
    assign b        = (rt_q == 5'd0) ? '0 : regs[rt_q];
    assign sum      = a + b;
    assign diff     = a - b;
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op_q)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a ^ b;
            4'b0011: res = ~(a | b);
            4'b0100: begin
                res = sum;
                ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            4'b0101: begin
                res = diff;
                ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
            4'b0110: res = {{(DW-1){1'b0}}, (a < b)};
            4'b0111: res = b << a[4:0];
            default: res = '0;
        endcase
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid && !ld_en;
                if (accept) state_next = EXEC;
            end
            EXEC: state_next = WB;
            WB: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_result <= '0;
            zero_flag  <= 1'b1;
            ovf_flag   <= 1'b0;
            op_q       <= '0;
            wr_q       <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && ld_en && ld_addr != 5'd0) regs[ld_addr] <= ld_data;
            if (accept) begin
                op_q <= alu_op;
                wr_q <= write_reg;
                rs_q <= rs_addr;
                rt_q <= rt_addr;
                rd_q <= rd_addr;
            end
            if (state == EXEC) begin
                alu_result <= res;
                zero_flag  <= (res == '0);
                ovf_flag   <= ovf;
            end
            // WB writes the value latched in EXEC, so the next EXEC sees it.
            if (state == WB && wr_q && rd_q != 5'd0) regs[rd_q] <= alu_result;
        end
    end

endmodule

// File: tb/tb_rtype_exec_wb.sv
// Directed bench for rtype_exec_wb: one task per scenario, each comparing
// observed outputs and register contents with hand-computed values.
module tb_rtype_exec_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  alu_op = '0;
  logic        write_reg = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        ovf_flag;
  logic        done;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] wb_result;
  logic        wb_zero;
  logic        wb_ovf;
  logic        wb_done;
  logic [31:0] rv;

  rtype_exec_wb #(.NREG(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_op(alu_op), .write_reg(write_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_result(alu_result), .zero_flag(zero_flag), .ovf_flag(ovf_flag),
    .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic peek(input logic [4:0] addr, output logic [31:0] val);
    @(negedge clk);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  // Issues one instruction from IDLE and captures outputs during WB.
  task automatic run_instr(input logic [3:0] op, input logic wr,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    alu_op = op; write_reg = wr; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    wb_result = alu_result; wb_zero = zero_flag; wb_ovf = ovf_flag; wb_done = done;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      peek(i[4:0], rv);
      checks++;
      if (rv !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", i, rv); end
    end
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
    checks++;
    if (zero_flag !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero_flag); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++;
    if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", alu_result); end
    checks++;
    if (ovf_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_flag); end
  endtask

  task automatic test_add();
    do_load(5'd1, 32'h5);
    do_load(5'd2, 32'h3);
    alu_op = 4'b0100; write_reg = 1'b1; rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3;
    dbg_addr = 5'd3;
    instr_valid = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready_pre got %b exp 1", instr_ready); end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL add_ready_exec got %b exp 0", instr_ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL add_done_exec got %b exp 0", done); end
    tick();
    checks++;
    if (alu_result !== 32'h8) begin errors++; $display("FAIL add_result got %h exp 8", alu_result); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL add_done_wb got %b exp 1", done); end
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL add_ready_wb got %b exp 0", instr_ready); end
    checks++;
    if (zero_flag !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++; $display("FAIL add_flags got z%b o%b exp z0 o0", zero_flag, ovf_flag);
    end
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL add_r3_early got %h exp 0", dbg_data); end
    tick();
    checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL add_back_idle got done%b ready%b exp done0 ready1", done, instr_ready);
    end
    checks++;
    if (dbg_data !== 32'h8) begin errors++; $display("FAIL add_r3 got %h exp 8", dbg_data); end
  endtask

  task automatic test_overflow();
    do_load(5'd1, 32'h7FFF_FFFF);
    do_load(5'd2, 32'h1);
    run_instr(4'b0100, 1'b1, 5'd1, 5'd2, 5'd4);
    checks++;
    if (wb_result !== 32'h8000_0000 || wb_ovf !== 1'b1 || wb_zero !== 1'b0) begin
      errors++; $display("FAIL ovf_add got %h o%b z%b exp 80000000 o1 z0", wb_result, wb_ovf, wb_zero);
    end
    peek(5'd4, rv);
    checks++;
    if (rv !== 32'h8000_0000) begin errors++; $display("FAIL ovf_r4 got %h exp 80000000", rv); end
    run_instr(4'b0101, 1'b1, 5'd2, 5'd2, 5'd5);
    checks++;
    if (wb_result !== 32'h0 || wb_zero !== 1'b1 || wb_ovf !== 1'b0) begin
      errors++; $display("FAIL sub_zero got %h z%b o%b exp 0 z1 o0", wb_result, wb_zero, wb_ovf);
    end
    run_instr(4'b0101, 1'b1, 5'd4, 5'd2, 5'd5);
    checks++;
    if (wb_result !== 32'h7FFF_FFFF || wb_ovf !== 1'b1) begin
      errors++; $display("FAIL sub_ovf got %h o%b exp 7fffffff o1", wb_result, wb_ovf);
    end
  endtask

  task automatic test_ops();
    do_load(5'd1, 32'h3);
    do_load(5'd2, 32'h1);
    run_instr(4'b0111, 1'b1, 5'd1, 5'd2, 5'd6);
    checks++;
    if (wb_result !== 32'h8) begin errors++; $display("FAIL sllv got %h exp 8", wb_result); end
    peek(5'd6, rv);
    checks++;
    if (rv !== 32'h8) begin errors++; $display("FAIL sllv_r6 got %h exp 8", rv); end
    run_instr(4'b0110, 1'b1, 5'd2, 5'd1, 5'd7);
    checks++;
    if (wb_result !== 32'h1) begin errors++; $display("FAIL sltu got %h exp 1", wb_result); end
    run_instr(4'b0011, 1'b1, 5'd0, 5'd0, 5'd8);
    checks++;
    if (wb_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nor got %h exp ffffffff", wb_result); end
    run_instr(4'b1010, 1'b1, 5'd1, 5'd2, 5'd9);
    checks++;
    if (wb_result !== 32'h0 || wb_zero !== 1'b1) begin
      errors++; $display("FAIL op1010 got %h z%b exp 0 z1", wb_result, wb_zero);
    end
    do_load(5'd10, 32'hF0F0_1234);
    do_load(5'd11, 32'h0FF0_00FF);
    run_instr(4'b0000, 1'b1, 5'd10, 5'd11, 5'd12);
    checks++;
    if (wb_result !== 32'h00F0_0034) begin errors++; $display("FAIL and got %h exp 00f00034", wb_result); end
    run_instr(4'b0001, 1'b1, 5'd10, 5'd11, 5'd12);
    checks++;
    if (wb_result !== 32'hFFF0_12FF) begin errors++; $display("FAIL or got %h exp fff012ff", wb_result); end
    run_instr(4'b0010, 1'b1, 5'd10, 5'd11, 5'd12);
    checks++;
    if (wb_result !== 32'hFF00_12CB) begin errors++; $display("FAIL xor got %h exp ff0012cb", wb_result); end
  endtask

  task automatic test_no_write();
    run_instr(4'b0100, 1'b0, 5'd1, 5'd1, 5'd13);
    checks++;
    if (wb_result !== 32'h6 || wb_done !== 1'b1) begin
      errors++; $display("FAIL nowr_result got %h done%b exp 6 done1", wb_result, wb_done);
    end
    peek(5'd13, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL nowr_r13 got %h exp 0", rv); end
    run_instr(4'b0100, 1'b1, 5'd1, 5'd1, 5'd0);
    do_load(5'd0, 32'hDEAD_BEEF);
    peek(5'd0, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL r0_write got %h exp 0", rv); end
    run_instr(4'b0001, 1'b1, 5'd0, 5'd0, 5'd13);
    checks++;
    if (wb_result !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp 0", wb_result); end
  endtask

  task automatic test_ld_priority();
    ld_en = 1'b1; ld_addr = 5'd14; ld_data = 32'h0000_ABCD;
    instr_valid = 1'b1; alu_op = 4'b0100; write_reg = 1'b1;
    rs_addr = 5'd1; rt_addr = 5'd1; rd_addr = 5'd15;
    tick();
    ld_en = 1'b0; instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL ldpri_ready got %b exp 1", instr_ready); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL ldpri_done got %b exp 0", done); end
    tick();
    peek(5'd14, rv);
    checks++;
    if (rv !== 32'h0000_ABCD) begin errors++; $display("FAIL ldpri_r14 got %h exp 0000abcd", rv); end
    peek(5'd15, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL ldpri_r15 got %h exp 0", rv); end
  endtask

  task automatic test_back_to_back();
    alu_op = 4'b0100; write_reg = 1'b1; rs_addr = 5'd1; rt_addr = 5'd1; rd_addr = 5'd16;
    dbg_addr = 5'd17;
    instr_valid = 1'b1;
    tick();
    ld_en = 1'b1; ld_addr = 5'd17; ld_data = 32'h55;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_exec got %b exp 0", instr_ready); end
    tick();
    checks++;
    if (done !== 1'b1 || alu_result !== 32'h6) begin
      errors++; $display("FAIL hold_wb got done%b %h exp done1 6", done, alu_result);
    end
    tick();
    ld_en = 1'b0;
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL hold_ld_ignored got %h exp 0", dbg_data); end
    rs_addr = 5'd16; rd_addr = 5'd18;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b exp 0", instr_ready); end
    tick();
    checks++;
    if (alu_result !== 32'h9) begin errors++; $display("FAIL b2b_result got %h exp 9", alu_result); end
    tick();
    peek(5'd18, rv);
    checks++;
    if (rv !== 32'h9) begin errors++; $display("FAIL b2b_r18 got %h exp 9", rv); end
  endtask

  task automatic test_reset_in_exec();
    alu_op = 4'b0100; write_reg = 1'b1; rs_addr = 5'd1; rt_addr = 5'd1; rd_addr = 5'd19;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL rstexec_ctrl got done%b ready%b exp done0 ready1", done, instr_ready);
    end
    checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1 || ovf_flag !== 1'b0) begin
      errors++; $display("FAIL rstexec_out got %h z%b o%b exp 0 z1 o0", alu_result, zero_flag, ovf_flag);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rstexec_no_wb got %b exp 0", done); end
    peek(5'd19, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL rstexec_r19 got %h exp 0", rv); end
    peek(5'd1, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL rstexec_r1 got %h exp 0", rv); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_ops();
    test_no_write();
    test_ld_priority();
    test_back_to_back();
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
